// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: round-robin arbiter sharing one leader-mode SPI engine between NREQ requesters.
module spi_txn_scheduler #(
    parameter int NREQ      = 2,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int GAP_CYC   = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    req_cfg,
    input  logic [16*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      err,
    output logic [15:0]          rdata,
    output logic [NREQ-1:0]      cs_n,
    output logic [7:0]           eng_cfg,
    output logic                 eng_cfg_load,
    output logic [15:0]          eng_wdata,
    output logic                 eng_start,
    input  logic                 eng_done,
    input  logic [15:0]          eng_rdata,
    output logic                 busy
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int MC = SETUP_CYC > HOLD_CYC ? (SETUP_CYC > GAP_CYC ? SETUP_CYC : GAP_CYC)
                                             : (HOLD_CYC > GAP_CYC ? HOLD_CYC : GAP_CYC);
    localparam int CW = MC > 1 ? $clog2(MC) : 1;
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, CFG, SETUP, START, WAIT, HOLD, GAP} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [TW-1:0]   tcnt, tcnt_d;
    logic [IW-1:0]   idx, idx_d, ptr, ptr_d, win, j;
    logic            len_q, len_d, tmo, tmo_d, found;
    logic [15:0]     res, res_d, rdata_d, wdata_d, wdat;
    logic [7:0]      eng_cfg_d, wcfg;
    logic [NREQ-1:0] cs_n_d, ack_d, err_d;
    logic            load_d, start_d;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        tcnt_d    = tcnt;
        idx_d     = idx;
        ptr_d     = ptr;
        len_d     = len_q;
        tmo_d     = tmo;
        res_d     = res;
        cs_n_d    = cs_n;
        ack_d     = '0;
        err_d     = '0;
        rdata_d   = rdata;
        eng_cfg_d = eng_cfg;
        wdata_d   = eng_wdata;
        load_d    = 1'b0;
        start_d   = 1'b0;
        found     = 1'b0;
        win       = '0;
        j         = '0;
        wcfg      = '0;
        wdat      = '0;
        // first set request at or after the pointer, wrapping
        for (int i = 0; i < NREQ; i++) begin
            j = IW'((int'(ptr) + i) % NREQ);
            if (!found && req[j]) begin
                found = 1'b1;
                win   = j;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (IW'(k) == win) begin
                wcfg = req_cfg[8*k +: 8];
                wdat = req_wdata[16*k +: 16];
            end
        end
        case (state)
            IDLE: if (found) begin
                state_d   = CFG;
                idx_d     = win;
                len_d     = wcfg[6];
                wdata_d   = wdat;
                eng_cfg_d = (wcfg | 8'h80) & 8'hFE;
                load_d    = 1'b1;
            end
            CFG: begin
                state_d = SETUP;
                cnt_d   = '0;
                cs_n_d  = ~(NREQ'(1) << idx);
            end
            SETUP: if (cnt == CW'(SETUP_CYC - 1)) begin
                state_d = START;
                start_d = 1'b1;
            end else begin
                cnt_d = cnt + 1'b1;
            end
            START: begin
                state_d = WAIT;
                tcnt_d  = '0;
                tmo_d   = 1'b0;
            end
            WAIT: if (eng_done) begin
                state_d = HOLD;
                cnt_d   = '0;
                res_d   = len_q ? eng_rdata : {8'h00, eng_rdata[7:0]};
            end else if (TIMEOUT != 0 && tcnt == TW'(TIMEOUT - 1)) begin
                state_d = HOLD;
                cnt_d   = '0;
                tmo_d   = 1'b1;
            end else begin
                tcnt_d = tcnt + TW'(tcnt != {TW{1'b1}});
            end
            HOLD: if (cnt == CW'(HOLD_CYC - 1)) begin
                state_d = GAP;
                cnt_d   = '0;
                cs_n_d  = '1;
                ptr_d   = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
                if (tmo) begin
                    err_d[idx] = 1'b1;
                end else begin
                    ack_d[idx] = 1'b1;
                    rdata_d    = res;
                end
            end else begin
                cnt_d = cnt + 1'b1;
            end
            GAP: if (cnt == CW'(GAP_CYC - 1)) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            tcnt         <= '0;
            idx          <= '0;
            ptr          <= '0;
            len_q        <= 1'b0;
            tmo          <= 1'b0;
            res          <= '0;
            cs_n         <= '1;
            ack          <= '0;
            err          <= '0;
            rdata        <= '0;
            eng_cfg      <= '0;
            eng_cfg_load <= 1'b0;
            eng_wdata    <= '0;
            eng_start    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            tcnt         <= tcnt_d;
            idx          <= idx_d;
            ptr          <= ptr_d;
            len_q        <= len_d;
            tmo          <= tmo_d;
            res          <= res_d;
            cs_n         <= cs_n_d;
            ack          <= ack_d;
            err          <= err_d;
            rdata        <= rdata_d;
            eng_cfg      <= eng_cfg_d;
            eng_cfg_load <= load_d;
            eng_wdata    <= wdata_d;
            eng_start    <= start_d;
            busy         <= state_d != IDLE;
        end
    end
endmodule

// File: tb/tb_spi_txn_scheduler.sv
// tb_spi_txn_scheduler: scoreboard bench for spi_txn_scheduler with a behavioural SPI engine.
module tb_spi_txn_scheduler;
    localparam int NREQ = 2, SETUP = 2, HOLD = 2, GAP = 4, TO = 16;

    typedef struct packed {
        logic [1:0]  a;
        logic [1:0]  e;
        logic [15:0] rd;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  req = '0;
    logic [15:0] req_cfg = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  ack, err, cs_n;
    logic [15:0] rdata, eng_wdata, eng_rdata;
    logic [7:0]  eng_cfg;
    logic        eng_cfg_load, eng_start, eng_done, busy;

    int   total = 0, bad = 0, cyc = 0;
    int   done_dly = -1;
    logic fixed = 1'b0;
    logic [15:0] eng_val = '0;
    exp_t sb[$];

    spi_txn_scheduler #(.NREQ(NREQ), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_cfg(req_cfg), .req_wdata(req_wdata),
        .ack(ack), .err(err), .rdata(rdata), .cs_n(cs_n), .eng_cfg(eng_cfg),
        .eng_cfg_load(eng_cfg_load), .eng_wdata(eng_wdata), .eng_start(eng_start),
        .eng_done(eng_done), .eng_rdata(eng_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // engine: pulses done done_dly cycles after start; answers ~wdata unless a fixed word is set
    initial begin
        eng_done  = 1'b0;
        eng_rdata = '0;
        forever begin
            @(negedge clk);
            if (eng_start && done_dly >= 0) begin
                repeat (done_dly) @(negedge clk);
                eng_done  = 1'b1;
                eng_rdata = fixed ? eng_val : ~eng_wdata;
                @(negedge clk);
                eng_done  = 1'b0;
                eng_rdata = '0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    endtask

    task automatic wait_start(input int lim, output int t);
        t = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (eng_start) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_resp(input int lim, output int t);
        t = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (ack !== 2'b00 || err !== 2'b00) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({cs_n, ack, err, eng_cfg_load, eng_start, busy, rdata, eng_cfg, eng_wdata} !== {2'b11, 2'b00, 2'b00, 3'b000, 16'h0, 8'h0, 16'h0}) begin
            bad++;
            $display("FAIL reset_values: got cs_n=%b ack=%b err=%b load=%b start=%b busy=%b rdata=%h cfg=%h wdata=%h, want 11/00/00/0/0/0/0/0/0",
                     cs_n, ack, err, eng_cfg_load, eng_start, busy, rdata, eng_cfg, eng_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        int   low;
        logic seen, got;
        do_reset();
        fixed = 1'b1;
        eng_val = 16'h123C;
        done_dly = 10;
        req_cfg[7:0] = 8'h20;
        req_wdata[15:0] = 16'h00A5;
        sb.push_back({2'b01, 2'b00, 16'h003C});
        req = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (eng_cfg_load) seen = 1'b1;
        end
        total++;
        if (!seen || eng_cfg !== 8'hA0) begin
            bad++;
            $display("FAIL single_cfg: got load=%b cfg=%h want 1/a0", seen, eng_cfg);
        end
        total++;
        if (eng_wdata !== 16'h00A5) begin
            bad++;
            $display("FAIL single_wdata: got %h want 00a5", eng_wdata);
        end
        low = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (cs_n === 2'b10) low++;
            if (ack !== 2'b00 || err !== 2'b00) got = 1'b1;
        end
        req = '0;
        total++;
        if (low != SETUP + 1 + 10 + HOLD) begin
            bad++;
            $display("FAIL single_cs_low: got %0d cycles want %0d", low, SETUP + 1 + 10 + HOLD);
        end
        e = sb.pop_front();
        total++;
        if ({ack, err, rdata} !== e) begin
            bad++;
            $display("FAIL single_resp: got ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h", ack, err, rdata, e.a, e.e, e.rd);
        end
        fixed = 1'b0;
        wait_idle();
    endtask

    task automatic test_contention();
        exp_t e;
        int   run, nack, ngap;
        logic zero;
        do_reset();
        done_dly = 3;
        req_cfg = {8'h40, 8'h40};
        req_wdata = {16'h0F0F, 16'hA0A0};
        sb.push_back({2'b01, 2'b00, 16'h5F5F});
        sb.push_back({2'b10, 2'b00, 16'hF0F0});
        sb.push_back({2'b01, 2'b00, 16'h5F5F});
        req = 2'b11;
        run = 0;
        nack = 0;
        ngap = 0;
        zero = 1'b0;
        for (int i = 0; i < 400 && nack < 3; i++) begin
            @(negedge clk);
            if (cs_n === 2'b00) zero = 1'b1;
            if (cs_n === 2'b11) begin
                run++;
            end else begin
                if (run > 0 && nack > 0) begin
                    ngap++;
                    total++;
                    if (run < GAP) begin
                        bad++;
                        $display("FAIL contention_gap: got %0d idle cycles want >=%0d", run, GAP);
                    end
                end
                run = 0;
            end
            if (ack !== 2'b00 || err !== 2'b00) begin
                nack++;
                if (nack == 3) req = '0;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL contention_extra: got ack=%b err=%b want none", ack, err);
                end else begin
                    e = sb.pop_front();
                    if ({ack, err, rdata} !== e) begin
                        bad++;
                        $display("FAIL contention_resp%0d: got ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h",
                                 nack, ack, err, rdata, e.a, e.e, e.rd);
                    end
                end
            end
        end
        req = '0;
        total++;
        if (nack != 3) begin
            bad++;
            $display("FAIL contention_count: got %0d responses want 3", nack);
        end
        total++;
        if (zero) begin
            bad++;
            $display("FAIL contention_cs: got cs_n=00 want never");
        end
        total++;
        if (ngap != 2) begin
            bad++;
            $display("FAIL contention_gaps: got %0d gaps want 2", ngap);
        end
        sb.delete();
        wait_idle();
    endtask

    task automatic test_done_boundary();
        exp_t e;
        int   t;
        done_dly = TO;
        req_cfg[7:0] = 8'h40;
        req_wdata[15:0] = 16'hBEEF;
        sb.push_back({2'b01, 2'b00, 16'h4110});
        req = 2'b01;
        wait_resp(100, t);
        req = '0;
        e = sb.pop_front();
        total++;
        if ({ack, err, rdata} !== e) begin
            bad++;
            $display("FAIL boundary_resp: got ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h", ack, err, rdata, e.a, e.e, e.rd);
        end
        wait_idle();
    endtask

    task automatic test_timeout();
        exp_t e;
        int   t0, t1;
        done_dly = -1;
        req_wdata[15:0] = 16'h7777;
        sb.push_back({2'b00, 2'b01, 16'h4110});
        req = 2'b01;
        wait_start(30, t0);
        wait_resp(100, t1);
        req = '0;
        total++;
        if (t0 < 0 || t1 < 0 || t1 - t0 != TO + HOLD + 1) begin
            bad++;
            $display("FAIL timeout_latency: got start=%0d resp=%0d want gap %0d", t0, t1, TO + HOLD + 1);
        end
        e = sb.pop_front();
        total++;
        if ({ack, err, rdata} !== e) begin
            bad++;
            $display("FAIL timeout_resp: got ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h", ack, err, rdata, e.a, e.e, e.rd);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        int   t, stray;
        done_dly = -1;
        req = 2'b01;
        wait_start(30, t);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        total++;
        if ({cs_n, busy, ack, err} !== {2'b11, 1'b0, 2'b00, 2'b00}) begin
            bad++;
            $display("FAIL rstwait_abort: got cs_n=%b busy=%b ack=%b err=%b want 11/0/00/00", cs_n, busy, ack, err);
        end
        rst = 1'b0;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack !== 2'b00 || err !== 2'b00 || busy) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL rstwait_quiet: got %0d active cycles want 0", stray);
        end
        done_dly = 5;
        req_cfg[15:8] = 8'h40;
        req_wdata[31:16] = 16'h1234;
        sb.push_back({2'b10, 2'b00, 16'hEDCB});
        req = 2'b10;
        wait_resp(100, t);
        req = '0;
        e = sb.pop_front();
        total++;
        if ({ack, err, rdata} !== e) begin
            bad++;
            $display("FAIL rstwait_resp: got ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h", ack, err, rdata, e.a, e.e, e.rd);
        end
        wait_idle();
    endtask

    task automatic test_early_drop();
        exp_t e;
        int   t, extra;
        logic seen;
        done_dly = 4;
        req_cfg[15:8] = 8'h00;
        req_wdata[31:16] = 16'h55AA;
        sb.push_back({2'b10, 2'b00, 16'h0055});
        req = 2'b10;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cs_n === 2'b01) seen = 1'b1;
        end
        req = '0;
        wait_resp(100, t);
        e = sb.pop_front();
        total++;
        if ({ack, err, rdata} !== e) begin
            bad++;
            $display("FAIL drop_resp: got ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h", ack, err, rdata, e.a, e.e, e.rd);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack !== 2'b00 || err !== 2'b00) extra++;
        end
        total++;
        if (extra != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_once: got extra=%0d busy=%b want 0/0", extra, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_done_boundary();
        test_timeout();
        test_reset_mid_wait();
        test_early_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
